// File: rtl/regfile_pkg.sv
// Shared types and sizes for the register-file write side.
package regfile_pkg;

  localparam int unsigned RegAddrW = 5;
  localparam int unsigned NumRegs  = 32;
  localparam int unsigned DataW    = 32;

  typedef struct packed {
    logic [RegAddrW-1:0] addr;
    logic [DataW-1:0]    data;
  } wb_entry_t;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    RELEASE = 2'd2
  } wr_state_e;

endpackage

// File: rtl/regfile_write_ctrl_wb_fifo.sv
// Writeback queue: Depth x wb_entry_t with wrap-bit pointers and a per-slot valid vector.
module wb_fifo
  import regfile_pkg::*;
#(
  parameter int unsigned Depth = 4
) (
  input  logic                                   clk_i,
  input  logic                                   rst_i,
  input  logic                                   push_i,
  input  wb_entry_t                              entry_i,
  input  logic                                   pop_i,
  output wb_entry_t                              head_o,
  output logic                                   full_o,
  output logic                                   empty_o,
  output logic [$clog2(Depth):0]                 count_o,
  output logic [Depth-1:0]                       valid_o,
  output logic [Depth-1:0][RegAddrW-1:0]         addrs_o
);

  localparam int unsigned PtrW = $clog2(Depth);

  wb_entry_t         mem_q [Depth];
  logic [PtrW:0]     wr_q, rd_q;
  logic              push_ok, pop_ok;

  assign full_o  = (wr_q[PtrW] != rd_q[PtrW]) && (wr_q[PtrW-1:0] == rd_q[PtrW-1:0]);
  assign empty_o = (wr_q == rd_q);
  assign count_o = wr_q - rd_q;
  assign head_o  = mem_q[rd_q[PtrW-1:0]];
  assign push_ok = push_i && !full_o;
  assign pop_ok  = pop_i && !empty_o;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_q <= '0;
      rd_q <= '0;
      for (int i = 0; i < int'(Depth); i++) mem_q[i] <= '0;
    end else begin
      if (push_ok) begin
        mem_q[wr_q[PtrW-1:0]] <= entry_i;
        wr_q                  <= wr_q + (PtrW+1)'(1);
      end
      if (pop_ok) rd_q <= rd_q + (PtrW+1)'(1);
    end
  end

  // Slot i is live when its distance from the read pointer is below the fill count.
  always_comb begin
    valid_o = '0;
    addrs_o = '0;
    for (int i = 0; i < int'(Depth); i++) begin
      valid_o[i] = {1'b0, PtrW'(PtrW'(i) - rd_q[PtrW-1:0])} < count_o;
      addrs_o[i] = mem_q[i].addr;
    end
  end

endmodule

// File: rtl/regfile_write_ctrl.sv
// Register-file write side: queues writebacks and drains them with a 4-phase req/ack handshake.
module regfile_write_ctrl
  import regfile_pkg::*;
#(
  parameter int unsigned DataWidth  = 32,
  parameter int unsigned Depth      = 4,
  parameter int unsigned SyncStages = 2
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       wb_valid_i,
  output logic                       wb_ready_o,
  input  logic [RegAddrW-1:0]        wb_addr_i,
  input  logic [DataWidth-1:0]       wb_data_i,
  output logic                       rf_req_w_o,
  output logic [RegAddrW-1:0]        rf_waddr_o,
  output logic [DataWidth-1:0]       rf_wdata_o,
  output logic                       rf_we_o,
  input  logic                       rf_ack_i,
  output logic [NumRegs-1:0]         pending_o,
  output logic [$clog2(Depth):0]     count_o,
  output logic                       idle_o
);

  wb_entry_t                     entry_in, head;
  logic                          full, empty, push_c, pop_c, ack_s;
  logic [Depth-1:0]              valid;
  logic [Depth-1:0][RegAddrW-1:0] addrs;

  wr_state_e                     state_q, state_d;
  logic                          req_q, req_d;
  logic [RegAddrW-1:0]           waddr_q, waddr_d;
  logic [DataWidth-1:0]          wdata_q, wdata_d;

  // x0 writes are handshaken on the input side but never stored.
  assign push_c   = wb_valid_i && !full && (wb_addr_i != '0);
  assign entry_in = '{addr: wb_addr_i, data: DataW'(wb_data_i)};

  wb_fifo #(.Depth(Depth)) u_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (push_c),
    .entry_i (entry_in),
    .pop_i   (pop_c),
    .head_o  (head),
    .full_o  (full),
    .empty_o (empty),
    .count_o (count_o),
    .valid_o (valid),
    .addrs_o (addrs)
  );

  if (SyncStages == 0) begin : g_nosync
    assign ack_s = rf_ack_i;
  end else begin : g_sync
    logic [SyncStages-1:0] sync_q;
    always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
        sync_q <= '0;
      end else begin
        sync_q[0] <= rf_ack_i;
        for (int i = 1; i < int'(SyncStages); i++) sync_q[i] <= sync_q[i-1];
      end
    end
    assign ack_s = sync_q[SyncStages-1];
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      req_q   <= 1'b0;
      waddr_q <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
    end
  end

  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    waddr_d = waddr_q;
    wdata_d = wdata_q;
    pop_c   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (!empty) begin
          waddr_d = head.addr;
          wdata_d = DataWidth'(head.data);
          req_d   = 1'b1;
          state_d = REQ;
        end
      end
      REQ: begin
        if (ack_s) begin
          req_d   = 1'b0;
          state_d = RELEASE;
        end
      end
      RELEASE: begin
        // Head stays queued (and pending) until the far side has dropped ack.
        if (!ack_s) begin
          pop_c   = 1'b1;
          state_d = IDLE;
        end
      end
      default: begin
        req_d   = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  always_comb begin
    pending_o = '0;
    for (int i = 0; i < int'(Depth); i++) begin
      if (valid[i]) pending_o[addrs[i]] = 1'b1;
    end
    pending_o[0] = 1'b0;
  end

  assign rf_req_w_o = req_q;
  assign rf_we_o    = req_q;
  assign rf_waddr_o = waddr_q;
  assign rf_wdata_o = wdata_q;
  assign wb_ready_o = !full;
  assign idle_o     = empty && (state_q == IDLE);

endmodule

// File: tb/tb_regfile_write_ctrl.sv
// Scoreboard bench for regfile_write_ctrl with a handshaking register-file responder.
module tb_regfile_write_ctrl;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b0;
  logic        wb_valid_i = 1'b0;
  logic        wb_ready_o;
  logic [4:0]  wb_addr_i = '0;
  logic [31:0] wb_data_i = '0;
  logic        rf_req_w_o;
  logic [4:0]  rf_waddr_o;
  logic [31:0] rf_wdata_o;
  logic        rf_we_o;
  logic        rf_ack_i = 1'b0;
  logic [31:0] pending_o;
  logic [2:0]  count_o;
  logic        idle_o;

  regfile_write_ctrl #(.DataWidth(32), .Depth(4), .SyncStages(2)) dut (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .wb_valid_i (wb_valid_i),
    .wb_ready_o (wb_ready_o),
    .wb_addr_i  (wb_addr_i),
    .wb_data_i  (wb_data_i),
    .rf_req_w_o (rf_req_w_o),
    .rf_waddr_o (rf_waddr_o),
    .rf_wdata_o (rf_wdata_o),
    .rf_we_o    (rf_we_o),
    .rf_ack_i   (rf_ack_i),
    .pending_o  (pending_o),
    .count_o    (count_o),
    .idle_o     (idle_o)
  );

  always #5 clk_i = ~clk_i;

  int          n_checks = 0;
  int          n_errors = 0;
  int          hs_cnt   = 0;
  int          ack_cnt  = 0;
  int          ack_delay = 2;
  bit          ack_hold = 1'b0;
  bit          prev_req = 1'b0;
  logic [36:0] exp_q [$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Register-file side: raise ack ack_delay cycles after req, drop it once req falls.
  always @(negedge clk_i) begin
    if (ack_hold || rst_i) begin
      rf_ack_i = 1'b0;
      ack_cnt  = 0;
    end else if (rf_req_w_o) begin
      if (ack_cnt >= ack_delay) rf_ack_i = 1'b1;
      else ack_cnt++;
    end else begin
      rf_ack_i = 1'b0;
      ack_cnt  = 0;
    end
  end

  // Each new request is matched against the oldest accepted non-x0 write.
  always @(negedge clk_i) begin
    logic [36:0] e;
    if (rst_i) begin
      prev_req = 1'b0;
    end else begin
      if (rf_req_w_o && !prev_req) begin
        hs_cnt++;
        if (exp_q.size() == 0) begin
          check("spurious_req", 1, 0);
        end else begin
          e = exp_q.pop_front();
          check("waddr", 64'(rf_waddr_o), 64'(e[36:32]));
          check("wdata", 64'(rf_wdata_o), 64'(e[31:0]));
          check("we_with_req", 64'(rf_we_o), 1);
        end
      end
      prev_req = rf_req_w_o;
    end
  end

  // Called at a negedge; returns at the negedge after acceptance.
  task automatic wb_write(input logic [4:0] a, input logic [31:0] d);
    int t = 0;
    wb_valid_i = 1'b1;
    wb_addr_i  = a;
    wb_data_i  = d;
    while (!wb_ready_o && t < 300) begin
      @(negedge clk_i);
      t++;
    end
    if (t >= 300) check("wb_accept_timeout", 1, 0);
    else if (a != 5'd0) exp_q.push_back({a, d});
    @(negedge clk_i);
    wb_valid_i = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int t = 0;
    while (!idle_o && t < 300) begin
      @(negedge clk_i);
      t++;
    end
    if (t >= 300) check(tag, 0, 1);
  endtask

  task automatic check_reset_vals(input string pfx);
    check({pfx, "_req"},     64'(rf_req_w_o), 0);
    check({pfx, "_we"},      64'(rf_we_o), 0);
    check({pfx, "_waddr"},   64'(rf_waddr_o), 0);
    check({pfx, "_wdata"},   64'(rf_wdata_o), 0);
    check({pfx, "_pending"}, 64'(pending_o), 0);
    check({pfx, "_count"},   64'(count_o), 0);
    check({pfx, "_idle"},    64'(idle_o), 1);
    check({pfx, "_ready"},   64'(wb_ready_o), 1);
  endtask

  initial begin
    int base;
    int t;

    // 1: asynchronous reset pulse mid-cycle
    #3 rst_i = 1'b1;
    #1 check_reset_vals("rst");
    @(negedge clk_i);
    rst_i = 1'b0;
    repeat (2) @(negedge clk_i);

    // 2: single write, request one edge after acceptance
    wb_write(5'd5, 32'hDEADBEEF);
    check("single_count", 64'(count_o), 1);
    check("single_pending", 64'(pending_o), 64'h20);
    check("single_req_not_yet", 64'(rf_req_w_o), 0);
    @(negedge clk_i);
    check("single_req_n1", 64'(rf_req_w_o), 1);
    check("single_pending_inflight", 64'(pending_o), 64'h20);
    wait_idle("single_idle_timeout");
    check("single_pending_done", 64'(pending_o), 0);
    check("single_hs", 64'(hs_cnt), 1);

    // 3: x0 write is consumed and dropped
    base = hs_cnt;
    wb_write(5'd0, 32'h1234);
    check("x0_count", 64'(count_o), 0);
    check("x0_idle", 64'(idle_o), 1);
    repeat (6) @(negedge clk_i);
    check("x0_no_req", 64'(hs_cnt - base), 0);

    // 4: fill with ack held low, fifth write waits for the first pop
    ack_hold = 1'b1;
    base = hs_cnt;
    for (int i = 1; i <= 4; i++) wb_write(5'(i), 32'h100 + 32'(i));
    check("fill_count", 64'(count_o), 4);
    check("fill_ready", 64'(wb_ready_o), 0);
    check("fill_pending", 64'(pending_o), 64'h1E);
    fork
      wb_write(5'd5, 32'h105);
      begin
        repeat (4) @(negedge clk_i);
        check("fill_still_full", 64'(count_o), 4);
        check("fill_still_blocked", 64'(wb_ready_o), 0);
        ack_hold = 1'b0;
      end
    join
    wait_idle("fill_idle_timeout");
    check("fill_hs", 64'(hs_cnt - base), 5);

    // 5: same-register hazard keeps bit 7 pending until the second pop
    base = hs_cnt;
    wb_write(5'd7, 32'h1);
    wb_write(5'd7, 32'h2);
    check("haz_pending", 64'(pending_o), 64'h80);
    t = 0;
    while (hs_cnt - base < 2 && t < 300) begin
      @(negedge clk_i);
      t++;
    end
    if (t >= 300) check("haz_second_req_timeout", 0, 1);
    check("haz_pending_second_inflight", 64'(pending_o[7]), 1);
    wait_idle("haz_idle_timeout");
    check("haz_pending_clear", 64'(pending_o), 0);
    check("sb_drained", 64'(exp_q.size()), 0);

    // 6: reset while a write sits in REQ abandons it
    ack_hold = 1'b1;
    base = hs_cnt;
    wb_write(5'd9, 32'h99);
    t = 0;
    while (!rf_req_w_o && t < 50) begin
      @(negedge clk_i);
      t++;
    end
    check("rst_req_reached", 64'(rf_req_w_o), 1);
    #2 rst_i = 1'b1;
    #1 check_reset_vals("midrst");
    exp_q.delete();
    @(negedge clk_i);
    rst_i = 1'b0;
    ack_hold = 1'b0;
    repeat (20) @(negedge clk_i);
    check("midrst_no_retry", 64'(hs_cnt - base), 1);
    check("midrst_idle", 64'(idle_o), 1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
